// File: rtl/analog_output_sequencer_if.sv
// Host-request / analog-stage control bundle for the output sequencer.
// master = host side (drives requests), slave = sequencer (drives the stage).
interface analog_output_sequencer_if;
  logic       req_enable;
  logic [7:0] req_mode;
  logic [7:0] req_volume;
  logic       thermal_shutdown;
  logic       fault_clear;
  logic       analog_power_enable;
  logic [7:0] out_mode;
  logic [7:0] out_volume;
  logic [7:0] out_mute;
  logic [2:0] seq_state;
  logic       busy;
  logic       fault;

  modport master (
    output req_enable, req_mode, req_volume, thermal_shutdown, fault_clear,
    input  analog_power_enable, out_mode, out_volume, out_mute, seq_state, busy, fault
  );

  modport slave (
    input  req_enable, req_mode, req_volume, thermal_shutdown, fault_clear,
    output analog_power_enable, out_mode, out_volume, out_mute, seq_state, busy, fault
  );
endinterface

// File: rtl/analog_output_sequencer.sv
// Pop-free analog output sequencer: bias settle, soft volume ramps, muted
// mode changes and sticky thermal shutdown. All outputs are registered.
module analog_output_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned RAMP_DIV      = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk_analog,
  input  logic                     rst_n,
  analog_output_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_POWER_UP   = 3'd1,
    S_RAMP_UP    = 3'd2,
    S_ACTIVE     = 3'd3,
    S_RAMP_DOWN  = 3'd4,
    S_POWER_DOWN = 3'd5,
    S_FAULT      = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RAMP_LAST   = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [7:0]       MUTE_ON     = 8'hFF;
  localparam logic [7:0]       MUTE_OFF    = 8'h00;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic             power_q, power_d;
  logic [7:0]       mode_q, mode_d;
  logic [7:0]       vol_q, vol_d;
  logic [7:0]       mute_q, mute_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  logic settle_done;
  logic ramp_tick;
  logic mode_diff;

  // One LSB toward the target; never passes it, so the volume cannot wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) return cur + 8'd1;
    if (cur > tgt) return cur - 8'd1;
    return cur;
  endfunction

  assign settle_done = (cnt_q == SETTLE_LAST);
  assign ramp_tick   = (pre_q == RAMP_LAST);
  assign mode_diff   = (bus.req_mode != mode_q);

  always_comb begin
    state_d = state_q;
    power_d = power_q;
    mode_d  = mode_q;
    vol_d   = vol_q;
    mute_d  = mute_q;
    fault_d = fault_q;
    cnt_d   = cnt_q + CNT_ONE;
    pre_d   = ramp_tick ? '0 : pre_q + CNT_ONE;

    unique case (state_q)
      S_OFF: begin
        if (bus.req_enable && !fault_q) begin
          power_d = 1'b1;
          mode_d  = bus.req_mode;
          state_d = S_POWER_UP;
        end
      end
      S_POWER_UP: begin
        if (settle_done) begin
          if (bus.req_enable) begin
            mute_d  = MUTE_OFF;
            state_d = S_RAMP_UP;
          end else begin
            state_d = S_POWER_DOWN;
          end
        end
      end
      S_RAMP_UP: begin
        if (!bus.req_enable || mode_diff) begin
          state_d = S_RAMP_DOWN;
        end else if (vol_q >= bus.req_volume) begin
          state_d = S_ACTIVE;
        end else if (ramp_tick) begin
          vol_d = step_toward(vol_q, bus.req_volume);
          if (vol_d == bus.req_volume) state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (!bus.req_enable || mode_diff) begin
          state_d = S_RAMP_DOWN;
        end else if (vol_q == bus.req_volume) begin
          pre_d = '0;
        end else if (ramp_tick) begin
          vol_d = step_toward(vol_q, bus.req_volume);
        end
      end
      S_RAMP_DOWN: begin
        // Once silent: mute, then either power down or swap mode before unmuting.
        if (vol_q != 8'd0) begin
          if (ramp_tick) begin
            vol_d = step_toward(vol_q, 8'd0);
            if (vol_d == 8'd0) mute_d = MUTE_ON;
          end
        end else if (mute_q != MUTE_ON) begin
          mute_d = MUTE_ON;
        end else if (!bus.req_enable) begin
          state_d = S_POWER_DOWN;
        end else if (mode_diff) begin
          mode_d = bus.req_mode;
        end else begin
          mute_d  = MUTE_OFF;
          state_d = S_RAMP_UP;
        end
      end
      S_POWER_DOWN: begin
        if (settle_done) begin
          power_d = 1'b0;
          state_d = S_OFF;
        end
      end
      S_FAULT: begin
        if (bus.fault_clear && !bus.thermal_shutdown) begin
          fault_d = 1'b0;
          state_d = S_OFF;
        end
      end
      default: state_d = S_OFF;
    endcase

    // Thermal trip outranks every other transition.
    if (bus.thermal_shutdown && state_q != S_FAULT) begin
      power_d = 1'b0;
      mute_d  = MUTE_ON;
      vol_d   = 8'd0;
      fault_d = 1'b1;
      state_d = S_FAULT;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
      pre_d = '0;
    end

    busy_d = (state_d inside {S_POWER_UP, S_RAMP_UP, S_RAMP_DOWN, S_POWER_DOWN});
  end

  always_ff @(posedge clk_analog or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pre_q   <= '0;
      power_q <= 1'b0;
      mode_q  <= 8'd0;
      vol_q   <= 8'd0;
      mute_q  <= MUTE_ON;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      power_q <= power_d;
      mode_q  <= mode_d;
      vol_q   <= vol_d;
      mute_q  <= mute_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign bus.analog_power_enable = power_q;
  assign bus.out_mode            = mode_q;
  assign bus.out_volume          = vol_q;
  assign bus.out_mute            = mute_q;
  assign bus.seq_state           = state_q;
  assign bus.busy                = busy_q;
  assign bus.fault               = fault_q;

endmodule
